// File: rtl/tc_array_pkg.sv
// Shared definitions for the tc_array timer block: per-channel FSM state
// encoding, register offsets inside a channel's 4-word window and the bit
// positions of the CTRL register fields.
package tc_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Register offsets (Addr[1:0])
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL field positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;
  localparam int unsigned CTRL_PSC_LO  = 8;
  localparam int unsigned CTRL_PSC_HI  = 15;

  // Only MODE=01 reloads; 00 and the reserved 1x codes behave as one-shot.
  localparam logic [1:0] MODE_RELOAD = 2'b01;

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, prescaler and the
// IDLE/LOAD/CNT/INT sequencer.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ctrl_we/preset_we/status_we  decoded write strobes for this channel
//   wdata                  write data
//   ctrl_rd/preset_rd/count_rd   32-bit read views (unused bits zero)
//   pending                STATUS bit0
//   irq                    pending AND IM
module tc_channel #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_we,
  input  logic        preset_we,
  input  logic        status_we,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] preset_rd,
  output logic [31:0] count_rd,
  output logic        pending,
  output logic        irq
);
  import tc_array_pkg::*;

  tc_state_e        state_q, state_d;
  logic             en_q;
  logic             im_q;
  logic [1:0]       mode_q;
  logic [7:0]       psc_q;
  logic [7:0]       psc_cnt_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             pending_q;

  logic tick;
  logic do_load;
  logic do_cnt;
  logic set_pend;
  logic clr_en;

  assign tick = (psc_cnt_q == psc_q);

  // Every action is gated by the registered EN: once EN reads 0 the channel
  // falls back to IDLE on the next edge without touching COUNT.
  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_cnt   = 1'b0;
    set_pend = 1'b0;
    clr_en   = 1'b0;
    if (!en_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_LOAD;
        ST_LOAD: begin
          do_load = 1'b1;
          state_d = ST_CNT;
        end
        ST_CNT: begin
          do_cnt = 1'b1;
          if (tick && (count_q == '0)) begin
            set_pend = 1'b1;
            state_d  = ST_INT;
          end
        end
        ST_INT: begin
          if (mode_q == MODE_RELOAD) begin
            state_d = ST_LOAD;
          end else begin
            clr_en  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A CTRL write takes priority over the one-shot EN self-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      mode_q <= '0;
      im_q   <= 1'b0;
      psc_q  <= '0;
    end else if (ctrl_we) begin
      en_q   <= wdata[CTRL_EN];
      mode_q <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
      im_q   <= wdata[CTRL_IM];
      psc_q  <= wdata[CTRL_PSC_HI:CTRL_PSC_LO];
    end else if (clr_en) begin
      en_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         preset_q <= '0;
    else if (preset_we) preset_q <= wdata[CNT_W-1:0];
  end

  // COUNT stops at zero; the terminal tick raises pending instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      psc_cnt_q <= '0;
    end else if (do_load) begin
      count_q   <= preset_q;
      psc_cnt_q <= '0;
    end else if (do_cnt) begin
      if (tick) begin
        psc_cnt_q <= '0;
        if (count_q != '0) count_q <= count_q - CNT_W'(1);
      end else begin
        psc_cnt_q <= psc_cnt_q + 8'd1;
      end
    end
  end

  // Setting wins over both clear sources in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                pending_q <= 1'b0;
    else if (set_pend)                         pending_q <= 1'b1;
    else if (ctrl_we || (status_we && wdata[0])) pending_q <= 1'b0;
  end

  always_comb begin
    ctrl_rd                           = '0;
    ctrl_rd[CTRL_EN]                  = en_q;
    ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
    ctrl_rd[CTRL_IM]                  = im_q;
    ctrl_rd[CTRL_PSC_HI:CTRL_PSC_LO]   = psc_q;
    preset_rd                         = '0;
    preset_rd[CNT_W-1:0]              = preset_q;
    count_rd                          = '0;
    count_rd[CNT_W-1:0]               = count_q;
  end

  assign pending = pending_q;
  assign irq     = pending_q & im_q;

endmodule

// File: rtl/tc_array.sv
// Array of N_CH independent down-counting timers behind a word-addressed
// register port.
// Ports:
//   clk      clock
//   reset    asynchronous active-low reset
//   WE       write strobe
//   Addr     word address {channel, reg[1:0]}
//   Din      write data
//   Dout     read data, combinational from Addr
//   IRQ      per-channel pending AND IM
//   IRQ_any  OR of IRQ
module tc_array #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned AW    = $clog2(N_CH) + 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            WE,
  input  logic [AW-1:0]   Addr,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic [N_CH-1:0] IRQ,
  output logic            IRQ_any
);
  import tc_array_pkg::*;

  logic [1:0]  reg_sel;
  logic [31:0] ch_sel;
  logic [31:0] rd_or [N_CH+1];

  assign reg_sel  = Addr[1:0];
  // Shift instead of slicing so a single-channel build (AW=2) stays legal;
  // indices >= N_CH match no channel and therefore read 0 / drop writes.
  assign ch_sel   = 32'(Addr) >> 2;
  assign rd_or[0] = '0;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic        sel;
    logic [31:0] ctrl_rd;
    logic [31:0] preset_rd;
    logic [31:0] count_rd;
    logic [31:0] rd_data;
    logic        pend;

    assign sel = (ch_sel == 32'(g));

    tc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst_n     (reset),
      .ctrl_we   (WE && sel && (reg_sel == REG_CTRL)),
      .preset_we (WE && sel && (reg_sel == REG_PRESET)),
      .status_we (WE && sel && (reg_sel == REG_STATUS)),
      .wdata     (Din),
      .ctrl_rd   (ctrl_rd),
      .preset_rd (preset_rd),
      .count_rd  (count_rd),
      .pending   (pend),
      .irq       (IRQ[g])
    );

    always_comb begin
      rd_data = '0;
      if (sel) begin
        case (reg_sel)
          REG_CTRL:   rd_data = ctrl_rd;
          REG_PRESET: rd_data = preset_rd;
          REG_COUNT:  rd_data = count_rd;
          default:    rd_data[0] = pend;
        endcase
      end
    end

    // At most one channel is selected, so OR-chaining forms the read mux.
    assign rd_or[g+1] = rd_or[g] | rd_data;
  end

  assign Dout    = rd_or[N_CH];
  assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_tc_array.sv
module tb_tc_array;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        we0, we1, we2;
  logic [2:0]  addr0;
  logic [3:0]  addr1, addr2;
  logic [31:0] din0, din1, din2;
  logic [31:0] dout0, dout1, dout2;
  logic [1:0]  irq0;
  logic [3:0]  irq1;
  logic [2:0]  irq2;
  logic        irq_any0, irq_any1, irq_any2;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  tc_array u_dut (
    .clk(clk), .reset(rst_n), .WE(we0), .Addr(addr0), .Din(din0),
    .Dout(dout0), .IRQ(irq0), .IRQ_any(irq_any0)
  );

  tc_array #(.N_CH(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .reset(rst_n), .WE(we1), .Addr(addr1), .Din(din1),
    .Dout(dout1), .IRQ(irq1), .IRQ_any(irq_any1)
  );

  tc_array #(.N_CH(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .reset(rst_n), .WE(we2), .Addr(addr2), .Din(din2),
    .Dout(dout2), .IRQ(irq2), .IRQ_any(irq_any2)
  );

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input int inst, input logic [3:0] a, input logic [31:0] d);
    case (inst)
      0:       begin we0 = 1'b1; addr0 = a[2:0]; din0 = d; end
      1:       begin we1 = 1'b1; addr1 = a;      din1 = d; end
      default: begin we2 = 1'b1; addr2 = a;      din2 = d; end
    endcase
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
  endtask

  task automatic rd(input int inst, input logic [3:0] a, output logic [31:0] d);
    case (inst)
      0:       addr0 = a[2:0];
      1:       addr1 = a;
      default: addr2 = a;
    endcase
    #1;
    case (inst)
      0:       d = dout0;
      1:       d = dout1;
      default: d = dout2;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  base;
    int          ch, p, s, m, q, u, dv, e_cnt, e_pend, e_en;
    logic [1:0]  e_irq;

    rst_n = 1'b0;
    we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    din0 = '0; din1 = '0; din2 = '0;

    tbl[0] = '{1'b1, 3'd0, 32'hFFFF_FFFE, 32'h0000_FF0E};
    tbl[1] = '{1'b1, 3'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 3'd2, 32'h0000_1234, 32'h0000_0000};
    tbl[3] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[4] = '{1'b1, 3'd4, 32'h0000_0A06, 32'h0000_0A06};
    tbl[5] = '{1'b1, 3'd5, 32'h0000_0001, 32'h0000_0001};
    tbl[6] = '{1'b0, 3'd0, 32'h0000_0000, 32'h0000_FF0E};
    tbl[7] = '{1'b0, 3'd1, 32'h0000_0000, 32'hDEAD_BEEF};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      rd(0, 4'(i), d);
      chk($sformatf("reset_reg%0d", i), d, 32'h0);
    end
    chk("reset_irq", 32'(irq0), 32'h0);
    chk("reset_irq_any", 32'(irq_any0), 32'h0);

    // Register access table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we) wr(0, {1'b0, tbl[i].addr}, tbl[i].din);
      rd(0, {1'b0, tbl[i].addr}, d);
      chk($sformatf("tbl%0d", i), d, tbl[i].exp);
    end

    // One-shot: PRESET=5, CTRL=EN|IM
    do_reset();
    wr(0, 4'd1, 32'd5);
    wr(0, 4'd0, 32'h9);
    repeat (7) @(negedge clk);
    chk("os_irq_e7", 32'(irq0), 32'h0);
    @(negedge clk);
    chk("os_irq_e8", 32'(irq0), 32'h1);
    chk("os_irq_any_e8", 32'(irq_any0), 32'h1);
    rd(0, 4'd2, d); chk("os_count_e8", d, 32'h0);
    rd(0, 4'd3, d); chk("os_status_e8", d, 32'h1);
    @(negedge clk);
    rd(0, 4'd0, d); chk("os_ctrl_en_cleared", d, 32'h8);
    repeat (4) @(negedge clk);
    rd(0, 4'd2, d); chk("os_count_idle", d, 32'h0);
    rd(0, 4'd3, d); chk("os_status_held", d, 32'h1);

    // Auto-reload on channel 1: PRESET=3 -> 6-cycle period
    do_reset();
    wr(0, 4'd5, 32'd3);
    wr(0, 4'd4, 32'hB);
    repeat (5) @(negedge clk);
    chk("ar_irq_pre", 32'(irq0), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ar%0d_irq_set", k), 32'(irq0), 32'h2);
      wr(0, 4'd7, 32'h1);
      chk($sformatf("ar%0d_irq_clr", k), 32'(irq0), 32'h0);
      repeat (4) @(negedge clk);
      chk($sformatf("ar%0d_irq_gap", k), 32'(irq0), 32'h0);
    end

    // Prescaler: PRESET=2, PSC=3
    do_reset();
    wr(0, 4'd1, 32'd2);
    wr(0, 4'd0, 32'h309);
    repeat (2) @(negedge clk);
    rd(0, 4'd2, d); chk("psc_count_load", d, 32'd2);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      rd(0, 4'd2, d);
      chk($sformatf("psc_count_%0d", i), d, (i < 12) ? 32'(2 - i / 4) : 32'd0);
      chk($sformatf("psc_irq_%0d", i), 32'(irq0), (i >= 12) ? 32'h1 : 32'h0);
    end

    // Collision of pending-set with STATUS W1C, IM=0
    do_reset();
    wr(0, 4'd1, 32'd1);
    wr(0, 4'd0, 32'h1);
    repeat (3) @(negedge clk);
    rd(0, 4'd3, d); chk("col_status_pre", d, 32'h0);
    wr(0, 4'd3, 32'h1);
    rd(0, 4'd3, d); chk("col_status_kept", d, 32'h1);
    chk("col_irq_masked", 32'(irq0), 32'h0);
    chk("col_irq_any_masked", 32'(irq_any0), 32'h0);
    wr(0, 4'd3, 32'h1);
    rd(0, 4'd3, d); chk("col_w1c", d, 32'h0);
    wr(0, 4'd0, 32'h1);
    repeat (4) @(negedge clk);
    rd(0, 4'd3, d); chk("ctrlclr_status_set", d, 32'h1);
    wr(0, 4'd0, 32'h0);
    rd(0, 4'd3, d); chk("ctrlclr_status_clr", d, 32'h0);

    // EN cleared mid-count freezes COUNT; PRESET write deferred to next LOAD
    do_reset();
    wr(0, 4'd1, 32'd50);
    wr(0, 4'd0, 32'h1);
    repeat (9) @(negedge clk);
    rd(0, 4'd2, d); chk("frz_count_e9", d, 32'd43);
    wr(0, 4'd1, 32'd7);
    rd(0, 4'd2, d); chk("frz_preset_deferred", d, 32'd42);
    wr(0, 4'd0, 32'h0);
    rd(0, 4'd2, d); chk("frz_count_e11", d, 32'd41);
    repeat (5) @(negedge clk);
    rd(0, 4'd2, d); chk("frz_count_held", d, 32'd41);
    rd(0, 4'd1, d); chk("frz_preset_rd", d, 32'd7);
    rd(0, 4'd3, d); chk("frz_status", d, 32'h0);
    wr(0, 4'd0, 32'h1);
    repeat (2) @(negedge clk);
    rd(0, 4'd2, d); chk("frz_reload_new_preset", d, 32'd7);

    // Reset in the middle of a count
    do_reset();
    wr(0, 4'd5, 32'd0);
    wr(0, 4'd4, 32'h9);
    wr(0, 4'd1, 32'd100);
    wr(0, 4'd0, 32'h9);
    repeat (2) @(negedge clk);
    rd(0, 4'd2, d); chk("rst_count_100", d, 32'd100);
    chk("rst_irq_any_pre", 32'(irq_any0), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("rst_irq_any_async", 32'(irq_any0), 32'h0);
    rd(0, 4'd2, d); chk("rst_count_async", d, 32'h0);
    rd(0, 4'd0, d); chk("rst_ctrl_async", d, 32'h0);
    rd(0, 4'd1, d); chk("rst_preset_async", d, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rd(0, 4'd3, d); chk("rst_status0_after", d, 32'h0);
    rd(0, 4'd7, d); chk("rst_status1_after", d, 32'h0);
    rd(0, 4'd2, d); chk("rst_count_after", d, 32'h0);
    chk("rst_irq_after", 32'(irq0), 32'h0);

    // N_CH=4, CNT_W=16 instance
    wr(1, 4'd13, 32'h0001_2345);
    rd(1, 4'd13, d); chk("n4_preset_trunc", d, 32'h0000_2345);
    wr(1, 4'd13, 32'd4);
    wr(1, 4'd12, 32'h9);
    repeat (6) @(negedge clk);
    chk("n4_irq_e6", 32'(irq1), 32'h0);
    @(negedge clk);
    chk("n4_irq_e7", 32'(irq1), 32'h8);
    chk("n4_irq_any", 32'(irq_any1), 32'h1);
    rd(1, 4'd2, d);  chk("n4_ch0_count", d, 32'h0);
    rd(1, 4'd14, d); chk("n4_ch3_count", d, 32'h0);
    rd(1, 4'd15, d); chk("n4_ch3_status", d, 32'h1);

    // N_CH=3, CNT_W=8 instance: channel 3 is unmapped
    wr(2, 4'd13, 32'd55);
    rd(2, 4'd13, d); chk("n3_unmapped_preset", d, 32'h0);
    wr(2, 4'd12, 32'h9);
    rd(2, 4'd12, d); chk("n3_unmapped_ctrl", d, 32'h0);
    wr(2, 4'd1, 32'h1FF);
    rd(2, 4'd1, d); chk("n3_preset_trunc", d, 32'hFF);
    repeat (10) @(negedge clk);
    chk("n3_irq_none", 32'(irq2), 32'h0);

    // Randomized runs against a closed-form timing model
    for (int trial = 0; trial < 10; trial++) begin
      do_reset();
      ch = int'($urandom_range(0, 1));
      p  = int'($urandom_range(0, 12));
      s  = int'($urandom_range(0, 3));
      m  = int'($urandom_range(0, 3));
      base = 4'(ch * 4);
      q  = (p + 1) * (s + 1) + 2;
      wr(0, base + 4'd1, 32'(p));
      wr(0, base, 32'(1 | (m << 1) | 8 | (s << 8)));
      for (int t = 0; t <= 2 * q + 3; t++) begin
        if (t > 0) @(negedge clk);
        if (t < 2) begin
          e_cnt = 0;
        end else begin
          u  = (m == 1) ? (t - 2) % q : (t - 2);
          dv = u / (s + 1);
          e_cnt = (dv > p) ? 0 : p - dv;
        end
        e_pend = (t >= q) ? 1 : 0;
        e_en   = (m == 1 || t <= q) ? 1 : 0;
        e_irq  = (e_pend != 0) ? 2'(1 << ch) : 2'b00;
        rd(0, base + 4'd2, d);
        chk($sformatf("rnd%0d_t%0d_count", trial, t), d, 32'(e_cnt));
        rd(0, base + 4'd3, d);
        chk($sformatf("rnd%0d_t%0d_status", trial, t), d, 32'(e_pend));
        rd(0, base, d);
        chk($sformatf("rnd%0d_t%0d_en", trial, t), 32'(d[0]), 32'(e_en));
        chk($sformatf("rnd%0d_t%0d_irq", trial, t), 32'(irq0), 32'(e_irq));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tc_array.md
TC_ARRAY -- requirements
Module: tc_array

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/preset width (8..32).
REQ-003 SHALL have parameter AW = $clog2(N_CH)+2 (N_CH=1 -> 2), derived word-address width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port WE  input  1  register write strobe.
REQ-007 SHALL have port Addr  input  AW  word address {channel, reg[1:0]}.
REQ-008 SHALL have port Din  input  32  write data.
REQ-009 SHALL have port Dout  output  32  read data, combinational from Addr.
REQ-010 SHALL have port IRQ  output  N_CH  per-channel interrupt, pending AND IM.
REQ-011 SHALL have port IRQ_any  output  1  OR-reduction of IRQ.

Function
REQ-012 SHALL map per channel: reg 0 CTRL (rw), reg 1 PRESET (rw), reg 2 COUNT (ro), reg 3 STATUS (bit0 pending; write-1-to-clear).
REQ-013 SHALL decode CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x reserved = one-shot), [3] IM, [15:8] PSC; other bits read 0.
REQ-014 SHALL ignore writes and read 0 for channel index >= N_CH and for COUNT writes; PRESET/COUNT read zero-extended to 32 bits.
REQ-015 SHALL run one FSM per channel: IDLE, LOAD, CNT, INT.
REQ-016 SHALL transition IDLE->LOAD at the edge after EN=1 is registered; LOAD: COUNT<=PRESET, prescaler<=0, ->CNT.
REQ-017 SHALL, in CNT, decrement COUNT once per tick (every PSC+1 cycles); when COUNT==0 at an edge -> INT and pending<=1.
REQ-018 SHALL, in INT: one-shot -> IDLE with EN cleared; auto-reload -> LOAD.
REQ-019 SHALL give, with PSC=0, first pending P+3 edges after the LOAD-state edge's preceding IDLE exit, i.e. pending visible 8 edges after the CTRL write for PRESET=5; auto-reload period P+3 cycles.
REQ-020 SHALL treat PRESET=0 as immediate: LOAD -> CNT -> INT without decrement, no underflow.
REQ-021 SHALL, on EN cleared by write in any state, go to IDLE next edge with COUNT frozen; pending unaffected.
REQ-022 SHALL apply a PRESET write during CNT only at the next LOAD.
REQ-023 SHALL, on simultaneous pending-set and STATUS W1C in one cycle, keep pending=1.
REQ-024 SHALL clear pending on any CTRL write.
REQ-025 SHALL keep channels fully independent; same-cycle events on different channels all take effect.

Reset
REQ-026 SHALL, on reset low, immediately force all channels: state IDLE, CTRL=0, PRESET=0, COUNT=0, prescaler=0, pending=0; IRQ=0, IRQ_any=0.
REQ-027 SHALL abort any in-progress count on reset without raising pending; operation resumes only after a new CTRL write.

Structure
REQ-028 SHALL place FSM state encodings, register offsets and CTRL bit positions in the shared macro include as constants.
REQ-029 SHALL implement one sub-module tc_channel (one channel: registers, prescaler, FSM) instantiated N_CH times by generate; tc_array holds address decode, read mux and IRQ OR.

Verification
REQ-030 SHALL verify one-shot: ch0 PRESET=5, CTRL=0x9 -> IRQ[0]=1 8 edges after write, COUNT=0, EN reads 0, state IDLE.
REQ-031 SHALL verify auto-reload: ch1 PRESET=3, CTRL=0xB -> pending at 6-cycle period; W1C STATUS each time clears IRQ[1] one edge later.
REQ-032 SHALL verify prescaler: PRESET=2, PSC=3 -> COUNT holds 4 cycles per decrement; pending 12 edges after LOAD-state.
REQ-033 SHALL verify collision: W1C STATUS in the pending-set cycle -> pending remains 1; IM=0 -> IRQ=0, STATUS bit0=1.
REQ-034 SHALL verify reset mid-count (COUNT=100) -> all registers 0, IRQ_any=0 asynchronously, no pending after release.
REQ-035 SHALL verify N_CH=4, CNT_W=16: PRESET write 0x12345 reads 0x2345; channel 3 runs alone; reads to unmapped addresses return 0.
